osd_scm_ctrl: RTL and testbench
===============================

// Module: osd_scm_ctrl
// PURPOSE
// Second-generation subnet control module register backend. Serves read-only system info
// (system id, module count, max packet length, CPU count) and adds system/CPU reset control
// with hold bits, self-timed reset pulses, a per-CPU reset mask and a scratch register.
// Sits behind osd_statctrlif (module id 16'h1) in the top-level SCM wrapper; drives the SoC reset tree.
// PARAMETERS
// SYSTEMID      16'h0  16-bit system identifier returned at 0x200
// NUM_MOD       1      number of debug modules, returned at 0x201
// MAX_PKT_LEN   12     max debug packet length in 16-bit words, returned at 0x202
// NUM_CPU       1      number of cpu_rst outputs, legal 1..16, returned at 0x203
// RST_PULSE_LEN 16     reset pulse length in clk cycles, legal >= 1
// PORTS
// clk          in   1        clock
// rst          in   1        asynchronous active-high reset
// reg_request  in   1        register access request, held until reg_ack or reg_err
// reg_write    in   1        1 = write, 0 = read
// reg_addr     in   16       register address
// reg_size     in   1        0 = 16-bit access (only legal size)
// reg_wdata    in   16       write data
// reg_ack      out  1        access completed OK, one-cycle pulse
// reg_err      out  1        access failed, one-cycle pulse
// reg_rdata    out  16       read data, valid with reg_ack
// sys_rst      out  1        system reset to SoC, active-high, registered
// cpu_rst      out  NUM_CPU  per-CPU reset, active-high, registered
// BEHAVIOUR
// - Reset: reg_ack=0, reg_err=0, reg_rdata=0, sys_rst=0, cpu_rst=0, SYSCTRL=0, CPU_MASK=all ones,
//   SCRATCH=0, both pulse counters 0, FSM=IDLE. rst never pulses sys_rst/cpu_rst.
// - Register map (16-bit):
//   0x200 SYSTEMID RO; 0x201 NUM_MOD RO; 0x202 MAX_PKT_LEN RO; 0x203 NUM_CPU RO
//   0x204 SYSCTRL RW: [0] sys hold, [1] cpu hold, [2] sys pulse (W1, reads 0), [3] cpu pulse (W1, reads 0)
//   0x205 CPU_MASK RW, bits [NUM_CPU-1:0]; upper bits write-ignored, read 0
//   0x206 RST_STATUS RO: [0] sys_rst, [1] sys pulse busy, [2] cpu pulse busy, [3] any cpu_rst
//   0x207 SCRATCH RW
// - Handshake FSM IDLE->RESP->IDLE. IDLE samples reg_request; RESP drives exactly one of reg_ack/reg_err
//   for one cycle with reg_rdata; request seen in RESP is ignored. Latency request->response = 1 cycle;
//   min spacing between accepted requests = 2 cycles. reg_rdata holds last value outside RESP.
// - reg_err when: addr outside 0x200..0x207, reg_size=1, or write to RO address. Errored writes change no state.
// - Write side effects take effect in the RESP cycle (state updated at IDLE->RESP edge).
// - Pulse: writing 1 to SYSCTRL[2] loads sys counter with RST_PULSE_LEN; counter decrements to 0;
//   busy = counter!=0. Write during busy restarts count (retrigger). Same for [3]/cpu counter.
//   Pulse and hold bits in the same write both apply.
// - sys_rst(next) = hold[0] | sys busy. cpu_rst[i](next) = sys_rst_int | ((hold[1] | cpu busy) & CPU_MASK[i]),
//   where sys_rst_int is the combinational next value of sys_rst, so cpu_rst never lags sys_rst.
// - Pulse width at output = exactly RST_PULSE_LEN cycles, first asserted cycle = cycle after RESP.
// - CPU_MASK change applies on the next edge, including mid-pulse.
// - Async rst mid-pulse: outputs drop immediately, counters clear, no resume after rst release.
// - Counter width $clog2(RST_PULSE_LEN+1); no wrap (saturates at 0).
// STRUCTURE
// - Package osd_scm_pkg: address localparams SCM_REG_SYSTEMID..SCM_REG_SCRATCH, SYSCTRL bit indices,
//   RST_STATUS bit indices, FSM state enum {IDLE, RESP}.
// - Sub-module osd_scm_rstgen #(LEN): trigger in, busy out, down-counter; instantiated twice (sys, cpu).
// TESTING
// - Read 0x200..0x203 with SYSTEMID=16'hBEEF, NUM_MOD=5, MAX_PKT_LEN=12, NUM_CPU=4 -> ack, rdata BEEF,5,12,4.
// - Write 0x200, read 0x208, read 0x204 with reg_size=1 -> reg_err each, no ack, state unchanged.
// - Write 0x204=16'h0004, RST_PULSE_LEN=16 -> sys_rst and cpu_rst=4'hF high exactly 16 cycles;
//   RST_STATUS[1]=1 when read mid-pulse.
// - CPU_MASK=4'b0101, write 0x204=16'h0002 -> cpu_rst=4'b0101, sys_rst=0; write 0x204=0 -> cpu_rst=0.
// - Retrigger: sys pulse at t, again at t+10 -> sys_rst continuously high until t+10+16 (RESP-relative).
// - Assert rst at cycle 5 of a pulse -> sys_rst/cpu_rst 0 same cycle, stay 0 after release, SCRATCH=0.

Source files
------------

// File: rtl/osd_scm_pkg.sv
// Shared definitions for the subnet control module register backend:
// register addresses, control/status bit positions and the handshake state type.
package osd_scm_pkg;

  localparam logic [15:0] SCM_REG_SYSTEMID   = 16'h0200;
  localparam logic [15:0] SCM_REG_NUM_MOD    = 16'h0201;
  localparam logic [15:0] SCM_REG_MAX_PKT    = 16'h0202;
  localparam logic [15:0] SCM_REG_NUM_CPU    = 16'h0203;
  localparam logic [15:0] SCM_REG_SYSCTRL    = 16'h0204;
  localparam logic [15:0] SCM_REG_CPU_MASK   = 16'h0205;
  localparam logic [15:0] SCM_REG_RST_STATUS = 16'h0206;
  localparam logic [15:0] SCM_REG_SCRATCH    = 16'h0207;

  localparam int SYSCTRL_SYS_HOLD  = 0;
  localparam int SYSCTRL_CPU_HOLD  = 1;
  localparam int SYSCTRL_SYS_PULSE = 2;
  localparam int SYSCTRL_CPU_PULSE = 3;

  localparam int STATUS_SYS_RST  = 0;
  localparam int STATUS_SYS_BUSY = 1;
  localparam int STATUS_CPU_BUSY = 2;
  localparam int STATUS_CPU_ANY  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } scm_state_e;

endpackage

// File: rtl/osd_scm_ctrl_if.sv
// Register access bus between the status/control front end (master)
// and the SCM register backend (slave).
interface osd_scm_ctrl_if;

  logic        reg_request;
  logic        reg_write;
  logic [15:0] reg_addr;
  logic        reg_size;
  logic [15:0] reg_wdata;
  logic        reg_ack;
  logic        reg_err;
  logic [15:0] reg_rdata;

  modport master (
    output reg_request, reg_write, reg_addr, reg_size, reg_wdata,
    input  reg_ack, reg_err, reg_rdata
  );

  modport slave (
    input  reg_request, reg_write, reg_addr, reg_size, reg_wdata,
    output reg_ack, reg_err, reg_rdata
  );

endinterface

// File: rtl/osd_scm_rstgen.sv
// Self-timed reset pulse generator: a trigger (re)loads a down-counter with LEN,
// busy stays high while the counter is non-zero.
module osd_scm_rstgen #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic busy
);

  localparam int CNT_W = $clog2(LEN + 1);

  logic [CNT_W-1:0] cnt_r;

  // Down-counter, retriggerable, holds at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (trigger) begin
      cnt_r <= CNT_W'(LEN);
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/osd_scm_ctrl.sv
// SCM register backend: read-only system info, system/CPU reset control with
// hold bits, self-timed pulses, per-CPU mask and a scratch register.
module osd_scm_ctrl
  import osd_scm_pkg::*;
#(
  parameter logic [15:0] SYSTEMID      = 16'h0000,
  parameter int          NUM_MOD       = 1,
  parameter int          MAX_PKT_LEN   = 12,
  parameter int          NUM_CPU       = 1,
  parameter int          RST_PULSE_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  osd_scm_ctrl_if.slave      bus,
  output logic               sys_rst,
  output logic [NUM_CPU-1:0] cpu_rst
);

  scm_state_e         state_r;
  logic [1:0]         hold_r;
  logic [NUM_CPU-1:0] cpu_mask_r;
  logic [15:0]        scratch_r;

  logic               addr_hit_s;
  logic               read_only_s;
  logic               err_s;
  logic               wr_s;
  logic [15:0]        rd_data_s;
  logic               sys_trig_s;
  logic               cpu_trig_s;
  logic               sys_busy_s;
  logic               cpu_busy_s;
  logic               sys_rst_int_s;
  logic [NUM_CPU-1:0] cpu_rst_int_s;

  // Address decode, error classification and read mux
  always_comb begin
    addr_hit_s  = 1'b1;
    read_only_s = 1'b0;
    rd_data_s   = 16'h0000;
    case (bus.reg_addr)
      SCM_REG_SYSTEMID: begin read_only_s = 1'b1; rd_data_s = SYSTEMID;         end
      SCM_REG_NUM_MOD:  begin read_only_s = 1'b1; rd_data_s = 16'(NUM_MOD);     end
      SCM_REG_MAX_PKT:  begin read_only_s = 1'b1; rd_data_s = 16'(MAX_PKT_LEN); end
      SCM_REG_NUM_CPU:  begin read_only_s = 1'b1; rd_data_s = 16'(NUM_CPU);     end
      SCM_REG_SYSCTRL: begin
        rd_data_s[SYSCTRL_SYS_HOLD] = hold_r[0];
        rd_data_s[SYSCTRL_CPU_HOLD] = hold_r[1];
      end
      SCM_REG_CPU_MASK: rd_data_s[NUM_CPU-1:0] = cpu_mask_r;
      SCM_REG_RST_STATUS: begin
        read_only_s                = 1'b1;
        rd_data_s[STATUS_SYS_RST]  = sys_rst;
        rd_data_s[STATUS_SYS_BUSY] = sys_busy_s;
        rd_data_s[STATUS_CPU_BUSY] = cpu_busy_s;
        rd_data_s[STATUS_CPU_ANY]  = |cpu_rst;
      end
      SCM_REG_SCRATCH: rd_data_s = scratch_r;
      default:         addr_hit_s = 1'b0;
    endcase
    err_s = !addr_hit_s || bus.reg_size || (bus.reg_write && read_only_s);
    wr_s  = (state_r == IDLE) && bus.reg_request && bus.reg_write && !err_s;
  end

  assign sys_trig_s = wr_s && (bus.reg_addr == SCM_REG_SYSCTRL) && bus.reg_wdata[SYSCTRL_SYS_PULSE];
  assign cpu_trig_s = wr_s && (bus.reg_addr == SCM_REG_SYSCTRL) && bus.reg_wdata[SYSCTRL_CPU_PULSE];

  osd_scm_rstgen #(.LEN(RST_PULSE_LEN)) u_sys_rstgen (
    .clk     (clk),
    .rst     (rst),
    .trigger (sys_trig_s),
    .busy    (sys_busy_s)
  );

  osd_scm_rstgen #(.LEN(RST_PULSE_LEN)) u_cpu_rstgen (
    .clk     (clk),
    .rst     (rst),
    .trigger (cpu_trig_s),
    .busy    (cpu_busy_s)
  );

  // CPU resets follow the next sys_rst value so they never lag behind it
  always_comb begin
    sys_rst_int_s = hold_r[0] | sys_busy_s;
    cpu_rst_int_s = {NUM_CPU{sys_rst_int_s}} | ({NUM_CPU{hold_r[1] | cpu_busy_s}} & cpu_mask_r);
  end

  // Handshake FSM, control registers and registered reset outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      bus.reg_ack   <= 1'b0;
      bus.reg_err   <= 1'b0;
      bus.reg_rdata <= 16'h0000;
      hold_r        <= 2'b00;
      cpu_mask_r    <= {NUM_CPU{1'b1}};
      scratch_r     <= 16'h0000;
      sys_rst       <= 1'b0;
      cpu_rst       <= {NUM_CPU{1'b0}};
    end else begin
      sys_rst <= sys_rst_int_s;
      cpu_rst <= cpu_rst_int_s;
      case (state_r)
        IDLE: begin
          bus.reg_ack <= 1'b0;
          bus.reg_err <= 1'b0;
          if (bus.reg_request) begin
            state_r     <= RESP;
            bus.reg_ack <= !err_s;
            bus.reg_err <= err_s;
            if (!err_s && !bus.reg_write) begin
              bus.reg_rdata <= rd_data_s;
            end
            if (wr_s) begin
              case (bus.reg_addr)
                SCM_REG_SYSCTRL:  hold_r <= {bus.reg_wdata[SYSCTRL_CPU_HOLD],
                                             bus.reg_wdata[SYSCTRL_SYS_HOLD]};
                SCM_REG_CPU_MASK: cpu_mask_r <= bus.reg_wdata[NUM_CPU-1:0];
                SCM_REG_SCRATCH:  scratch_r  <= bus.reg_wdata;
                default:          ;
              endcase
            end
          end
        end
        RESP: begin
          state_r     <= IDLE;
          bus.reg_ack <= 1'b0;
          bus.reg_err <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          bus.reg_ack <= 1'b0;
          bus.reg_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_scm_ctrl.sv
// Randomized self-checking bench for osd_scm_ctrl against a cycle-indexed
// reference model (pulse windows, hold bits, mask) plus directed scenarios.
module tb_osd_scm_ctrl;

  localparam int NCPU = 4;
  localparam int PLEN = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sys_rst;
  logic [NCPU-1:0] cpu_rst;

  always #5 clk = ~clk;

  osd_scm_ctrl_if bus ();

  osd_scm_ctrl #(
    .SYSTEMID      (16'hBEEF),
    .NUM_MOD       (5),
    .MAX_PKT_LEN   (12),
    .NUM_CPU       (NCPU),
    .RST_PULSE_LEN (PLEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sys_rst (sys_rst),
    .cpu_rst (cpu_rst)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hi_cnt   = 0;

  // Model: register contents plus pulse windows as inclusive output-cycle ranges
  logic [1:0]      m_hold;
  logic [NCPU-1:0] m_mask;
  logic [15:0]     m_scratch;
  logic [15:0]     m_rdata;
  int              s_start, s_end, c_start, c_end;
  bit              m_in_resp;
  logic            e_sys;
  logic [NCPU-1:0] e_cpu;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit win(input int s, input int e, input int n);
    return (n >= s) && (n <= e);
  endfunction

  task automatic model_reset();
    m_hold    = 2'b00;
    m_mask    = {NCPU{1'b1}};
    m_scratch = 16'h0000;
    m_rdata   = 16'h0000;
    s_start = 1; s_end = 0; c_start = 1; c_end = 0;
    m_in_resp = 1'b0;
    e_sys     = 1'b0;
    e_cpu     = {NCPU{1'b0}};
  endtask

  function automatic logic [15:0] read_model(input logic [15:0] a);
    case (a)
      16'h0200: return 16'hBEEF;
      16'h0201: return 16'd5;
      16'h0202: return 16'd12;
      16'h0203: return 16'(NCPU);
      16'h0204: return {14'b0, m_hold};
      16'h0205: return {12'b0, m_mask};
      16'h0206: return {12'b0, |e_cpu, win(c_start, c_end, cyc), win(s_start, s_end, cyc), e_sys};
      16'h0207: return m_scratch;
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic write_model(input logic [15:0] a, input logic [15:0] d);
    case (a)
      16'h0204: begin
        m_hold = d[1:0];
        if (d[2]) begin
          if (s_end < cyc + 1) s_start = cyc + 1;
          s_end = cyc + PLEN;
        end
        if (d[3]) begin
          if (c_end < cyc + 1) c_start = cyc + 1;
          c_end = cyc + PLEN;
        end
      end
      16'h0205: m_mask = d[NCPU-1:0];
      16'h0207: m_scratch = d;
      default: ;
    endcase
  endtask

  // One clock: predict outputs from pre-edge model, apply any accepted access, compare
  task automatic tick();
    logic            n_sys;
    logic [NCPU-1:0] n_cpu;
    logic            x_ack, x_err;
    bit              fire;
    logic [15:0]     a;
    @(posedge clk);
    cyc++;
    n_sys = m_hold[0] | win(s_start, s_end, cyc);
    n_cpu = {NCPU{n_sys}} | ({NCPU{m_hold[1] | win(c_start, c_end, cyc)}} & m_mask);
    x_ack = 1'b0;
    x_err = 1'b0;
    fire  = bus.reg_request && !m_in_resp;
    m_in_resp = fire;
    if (fire) begin
      a = bus.reg_addr;
      x_err = (a < 16'h0200) || (a > 16'h0207) || bus.reg_size ||
              (bus.reg_write && ((a <= 16'h0203) || (a == 16'h0206)));
      x_ack = !x_err;
      if (x_ack && !bus.reg_write) m_rdata = read_model(a);
      else if (x_ack) write_model(a, bus.reg_wdata);
    end
    #1;
    check_eq("sys_rst", sys_rst, n_sys);
    check_eq("cpu_rst", cpu_rst, n_cpu);
    check_eq("reg_ack", bus.reg_ack, x_ack);
    check_eq("reg_err", bus.reg_err, x_err);
    check_eq("reg_rdata", bus.reg_rdata, m_rdata);
    if (sys_rst === 1'b1) hi_cnt++;
    e_sys = n_sys;
    e_cpu = n_cpu;
  endtask

  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd, input bit sz);
    bus.reg_request = 1'b1;
    bus.reg_write   = wr;
    bus.reg_addr    = addr;
    bus.reg_wdata   = wd;
    bus.reg_size    = sz;
    tick();
    bus.reg_request = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_sys_rst", sys_rst, 1'b0);
    check_eq("rst_cpu_rst", cpu_rst, {NCPU{1'b0}});
    check_eq("rst_ack", bus.reg_ack, 1'b0);
    check_eq("rst_rdata", bus.reg_rdata, 16'h0000);
    model_reset();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] ro_exp [4];
    ro_exp = '{16'hBEEF, 16'd5, 16'd12, 16'd4};
    bus.reg_request = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg_addr    = 16'h0000;
    bus.reg_size    = 1'b0;
    bus.reg_wdata   = 16'h0000;
    model_reset();
    apply_reset();

    // Read-only info
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 16'h0200 + 16'(i), 16'h0000, 1'b0);
      check_eq("ro_info", bus.reg_rdata, ro_exp[i]);
    end

    // Error cases leave state unchanged
    access(1'b1, 16'h0200, 16'h1234, 1'b0);
    access(1'b0, 16'h0208, 16'h0000, 1'b0);
    access(1'b1, 16'h0207, 16'h5A5A, 1'b1);
    access(1'b0, 16'h0204, 16'h0000, 1'b1);
    access(1'b0, 16'h0200, 16'h0000, 1'b0);
    check_eq("sysid_after_err", bus.reg_rdata, 16'hBEEF);

    // Request held into RESP is accepted only once
    bus.reg_request = 1'b1; bus.reg_write = 1'b1; bus.reg_addr = 16'h0207;
    bus.reg_wdata = 16'hC0DE; bus.reg_size = 1'b0;
    tick(); tick();
    bus.reg_request = 1'b0;
    tick();
    access(1'b0, 16'h0207, 16'h0000, 1'b0);
    check_eq("scratch_rw", bus.reg_rdata, 16'hC0DE);

    // Single sys pulse width
    hi_cnt = 0;
    access(1'b1, 16'h0204, 16'h0004, 1'b0);
    check_eq("pulse_cpu_all", cpu_rst, 4'hF);
    for (int i = 0; i < 24; i++) tick();
    check_eq("pulse_width", hi_cnt, 16);

    // Status read mid-pulse
    access(1'b1, 16'h0204, 16'h0004, 1'b0);
    tick(); tick();
    access(1'b0, 16'h0206, 16'h0000, 1'b0);
    check_eq("status_busy", bus.reg_rdata[1], 1'b1);
    for (int i = 0; i < 20; i++) tick();

    // Masked CPU hold
    access(1'b1, 16'h0205, 16'h0005, 1'b0);
    access(1'b1, 16'h0204, 16'h0002, 1'b0);
    check_eq("mask_cpu_rst", cpu_rst, 4'b0101);
    check_eq("mask_sys_rst", sys_rst, 1'b0);
    access(1'b1, 16'h0204, 16'h0000, 1'b0);
    check_eq("hold_clear", cpu_rst, 4'b0000);

    // Retrigger: second pulse 10 cycles after the first
    hi_cnt = 0;
    access(1'b1, 16'h0204, 16'h0004, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    access(1'b1, 16'h0204, 16'h0004, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    check_eq("retrigger_len", hi_cnt, 26);

    // Reset mid-pulse
    access(1'b1, 16'h0207, 16'h7777, 1'b0);
    access(1'b1, 16'h0204, 16'h000C, 1'b0);
    tick(); tick(); tick();
    apply_reset();
    for (int i = 0; i < 20; i++) tick();
    access(1'b0, 16'h0207, 16'h0000, 1'b0);
    check_eq("scratch_after_rst", bus.reg_rdata, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h01FF + 16'($urandom_range(0, 9));
      access(1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 7) == 0));
      for (int g = $urandom_range(0, 6); g > 0; g--) tick();
      if ($urandom_range(0, 59) == 0) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
